// File: rtl/execute_stage_pipe_pkg.sv
// exec_pkg: opcode, flag-index and FSM-state definitions shared by the EX stage.
`default_nettype none

package exec_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_NOT = 3'b100;
  localparam logic [2:0] ALU_SHL = 3'b101;
  localparam logic [2:0] ALU_SHR = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b111;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/execute_stage_pipe_if.sv
// execute_stage_pipe_if: ID/EX operand handshake and EX/MEM result bus.
`default_nettype none

interface execute_stage_pipe_if #(
  parameter int WIDTH = 16,
  parameter int DST_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [2:0]       alu_mode;
  logic [DST_W-1:0] dst_in;
  logic             stall;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] result_r;
  logic [DST_W-1:0] dst_r;
  logic [2:0]       flags_r;

  modport master (
    output in_valid, op1, op2, alu_mode, dst_in, stall, flush,
    input  in_ready, out_valid, result_r, dst_r, flags_r
  );

  modport slave (
    input  in_valid, op1, op2, alu_mode, dst_in, stall, flush,
    output in_ready, out_valid, result_r, dst_r, flags_r
  );
endinterface

`default_nettype wire

// File: rtl/execute_stage_pipe_mul.sv
// mul_iter: iterative shift-add multiplier, one partial product per cycle, WIDTH cycles.
`default_nettype none

module mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // done marks the cycle in which the final iteration is being committed
  assign done    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign busy    = busy_q;
  assign product = acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (clear) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= op_a;
      b_q    <= op_b;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (b_q[0]) acc_q <= acc_q + a_q;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end
endmodule

`default_nettype wire

// File: rtl/execute_stage_pipe.sv
// execute_stage_pipe: EX stage with single-cycle ALU, iterative MUL, flags and the EX/MEM register.
`default_nettype none

module execute_stage_pipe
  import exec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DST_W = 3,
  parameter int SH_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  execute_stage_pipe_if.slave   bus
);
  state_t           state_q, state_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [DST_W-1:0] dst_q, mul_dst_q;
  logic [2:0]       flags_q;

  logic             accept, start_mul;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_prod;

  logic [WIDTH:0]   alu_wide;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic [SH_W-1:0]  amt;
  logic [2:0]       alu_flags, mul_flags;

  assign bus.in_ready  = !reset && (state_q == S_IDLE) && !mul_busy && !bus.stall && !bus.flush;
  assign accept        = bus.in_valid && bus.in_ready;
  assign start_mul     = accept && (bus.alu_mode == ALU_MUL);
  assign amt           = bus.op2[SH_W-1:0];

  assign bus.out_valid = out_valid_q;
  assign bus.result_r  = result_q;
  assign bus.dst_r     = dst_q;
  assign bus.flags_r   = flags_q;

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus.flush),
    .start   (start_mul),
    .op_a    (bus.op1),
    .op_b    (bus.op2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Carry/borrow and the shifted-out bit all fall out of a WIDTH+1 wide intermediate
  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    case (bus.alu_mode)
      ALU_ADD: begin
        alu_wide = {1'b0, bus.op1} + {1'b0, bus.op2};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      ALU_SUB: begin
        alu_wide = {1'b0, bus.op1} - {1'b0, bus.op2};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      ALU_AND: alu_res = bus.op1 & bus.op2;
      ALU_OR:  alu_res = bus.op1 | bus.op2;
      ALU_NOT: alu_res = ~bus.op1;
      ALU_SHL: begin
        alu_wide = {1'b0, bus.op1} << amt;
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      ALU_SHR: begin
        alu_wide = {bus.op1, 1'b0} >> amt;
        alu_res  = alu_wide[WIDTH:1];
        alu_c    = alu_wide[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_flags        = '0;
    alu_flags[FLG_Z] = (alu_res == '0);
    alu_flags[FLG_N] = alu_res[WIDTH-1];
    alu_flags[FLG_C] = alu_c;
    mul_flags        = '0;
    mul_flags[FLG_Z] = (mul_prod == '0);
    mul_flags[FLG_N] = mul_prod[WIDTH-1];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_mul) state_d = S_MUL;
      S_MUL:   if (bus.flush) state_d = S_IDLE;
               else if (mul_done) state_d = S_DONE;
      S_DONE:  if (bus.flush || !bus.stall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      dst_q       <= '0;
      flags_q     <= '0;
      mul_dst_q   <= '0;
    end else begin
      state_q <= state_d;
      if (start_mul) mul_dst_q <= bus.dst_in;
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (bus.stall) begin
        out_valid_q <= out_valid_q;
      end else if (accept && !start_mul) begin
        out_valid_q <= 1'b1;
        result_q    <= alu_res;
        dst_q       <= bus.dst_in;
        flags_q     <= alu_flags;
      end else if (state_q == S_DONE) begin
        out_valid_q <= 1'b1;
        result_q    <= mul_prod;
        dst_q       <= mul_dst_q;
        flags_q     <= mul_flags;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_execute_stage_pipe.sv
// tb_execute_stage_pipe: directed stimulus with a queue scoreboard checked by an output monitor.
`default_nettype none

module tb_execute_stage_pipe;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic stall_at_edge;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  dst;
    logic [2:0]  flg;
  } exp_t;

  exp_t exp_q[$];

  execute_stage_pipe_if #(.WIDTH(16), .DST_W(3)) bus ();

  execute_stage_pipe #(.WIDTH(16), .DST_W(3), .SH_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [15:0] r, input logic [2:0] d, input logic [2:0] f);
    exp_t e;
    e.res = r;
    e.dst = d;
    e.flg = f;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] m, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] d);
    bus.in_valid = 1'b1;
    bus.alu_mode = m;
    bus.op1      = a;
    bus.op2      = b;
    bus.dst_in   = d;
    #1;
    chk("in_ready_at_issue", {31'd0, bus.in_ready}, 32'd1);
    step();
    bus.in_valid = 1'b0;
  endtask

  always @(posedge clk) stall_at_edge <= bus.stall;

  // A fresh result appears after every edge that was not stalled and left out_valid high
  always @(negedge clk) begin
    if (!reset && bus.out_valid && !stall_at_edge) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", {31'd0, bus.out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_r", {16'd0, bus.result_r}, {16'd0, e.res});
        chk("dst_r",    {29'd0, bus.dst_r},    {29'd0, e.dst});
        chk("flags_r",  {29'd0, bus.flags_r},  {29'd0, e.flg});
      end
    end
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    stall_at_edge = 1'b0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.alu_mode  = '0;
    bus.dst_in    = '0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    #2;
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_result",    {16'd0, bus.result_r},  32'd0);
    chk("reset_flags",     {29'd0, bus.flags_r},   32'd0);
    chk("reset_in_ready",  {31'd0, bus.in_ready},  32'd0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

    // Single-cycle ALU vectors: flags are {C,N,Z}
    expect_out(16'h0000, 3'd5, 3'b101); issue(3'b000, 16'hFFFF, 16'h0001, 3'd5);
    expect_out(16'hFFFE, 3'd1, 3'b110); issue(3'b001, 16'h0003, 16'h0005, 3'd1);
    expect_out(16'h0002, 3'd2, 3'b100); issue(3'b101, 16'h8001, 16'h0001, 3'd2);
    expect_out(16'h0001, 3'd3, 3'b100); issue(3'b110, 16'h0003, 16'h0001, 3'd3);
    expect_out(16'h00F0, 3'd4, 3'b000); issue(3'b010, 16'hF0F0, 16'h0FF0, 3'd4);
    expect_out(16'h8001, 3'd6, 3'b010); issue(3'b011, 16'h8000, 16'h0001, 3'd6);
    expect_out(16'h0000, 3'd7, 3'b001); issue(3'b100, 16'hFFFF, 16'h1234, 3'd7);
    expect_out(16'h1234, 3'd0, 3'b000); issue(3'b101, 16'h1234, 16'h0010, 3'd0);
    expect_out(16'h8000, 3'd1, 3'b010); issue(3'b000, 16'h7FFF, 16'h0001, 3'd1);
    step();
    chk("bubble_out_valid", {31'd0, bus.out_valid}, 32'd0);

    // MUL 3*5: busy for WIDTH+1 cycles, then one result
    expect_out(16'h000F, 3'd4, 3'b000); issue(3'b111, 16'h0003, 16'h0005, 3'd4);
    for (int k = 0; k < 17; k++) begin
      chk("mul_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      step();
    end
    chk("mul_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("mul_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
    step();

    // Stall freezes a produced result; the pending op lands only after release
    expect_out(16'h0030, 3'd6, 3'b000); issue(3'b000, 16'h0010, 16'h0020, 3'd6);
    bus.stall    = 1'b1;
    bus.in_valid = 1'b1;
    bus.alu_mode = 3'b000;
    bus.op1      = 16'h0001;
    bus.op2      = 16'h0001;
    bus.dst_in   = 3'd7;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_result", {16'd0, bus.result_r}, 32'h0030);
      step();
    end
    chk("stall_result_end", {16'd0, bus.result_r}, 32'h0030);
    bus.stall = 1'b0;
    #1;
    chk("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
    expect_out(16'h0002, 3'd7, 3'b000);
    step();
    bus.in_valid = 1'b0;
    step();

    // MUL flushed at cnt==7 produces nothing
    issue(3'b111, 16'h1234, 16'h0002, 3'd1);
    for (int k = 0; k < 7; k++) step();
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    chk("flush_blocks_accept", {31'd0, bus.in_ready}, 32'd0);
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      chk("flush_no_output", {31'd0, bus.out_valid}, 32'd0);
      step();
    end
    expect_out(16'h0005, 3'd2, 3'b000); issue(3'b000, 16'h0002, 16'h0003, 3'd2);
    step();

    // Asynchronous reset in the middle of a MUL
    issue(3'b111, 16'h0003, 16'h0003, 3'd5);
    for (int k = 0; k < 5; k++) step();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mul_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mul_result", {16'd0, bus.result_r}, 32'd0);
    chk("rst_mul_dst", {29'd0, bus.dst_r}, 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rst_mul_idle", {31'd0, bus.in_ready}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      chk("rst_mul_no_output", {31'd0, bus.out_valid}, 32'd0);
      step();
    end

    // Asynchronous reset while a result is held by stall
    expect_out(16'h0100, 3'd3, 3'b000); issue(3'b000, 16'h00FF, 16'h0001, 3'd3);
    bus.stall = 1'b1;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_stall_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_stall_result", {16'd0, bus.result_r}, 32'd0);
    chk("rst_stall_flags", {29'd0, bus.flags_r}, 32'd0);
    step();
    reset     = 1'b0;
    bus.stall = 1'b0;
    #1;
    chk("rst_stall_idle", {31'd0, bus.in_ready}, 32'd1);
    expect_out(16'h0002, 3'd4, 3'b000); issue(3'b000, 16'h0001, 16'h0001, 3'd4);
    step();
    step();

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
